// File: rtl/demux_stream.sv
// Registered 1-to-2 stream demultiplexer: routes each accepted input word to
// channel A or B (explicit select or automatic alternation), with per-channel counters.
module demux_stream #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s,
  input  logic             auto,
  input  logic             clr,
  output logic [WIDTH-1:0] q_a,
  output logic             valid_a,
  input  logic             ready_a,
  output logic [WIDTH-1:0] q_b,
  output logic             valid_b,
  input  logic             ready_b,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic [WIDTH-1:0] r_q_a, r_q_b;
  logic             r_valid_a, r_valid_b;
  logic [CNT_W-1:0] r_cnt_a, r_cnt_b;
  logic             r_turn;

  logic w_dst, w_free_a, w_free_b, w_accept, w_acc_a, w_acc_b;

  always_comb begin
    w_dst    = auto ? r_turn : s;
    w_free_a = !r_valid_a || ready_a;
    w_free_b = !r_valid_b || ready_b;
    // Readiness depends only on the destination slot, never on in_valid
    in_ready = w_dst ? w_free_b : w_free_a;
    w_accept = in_valid && in_ready;
    w_acc_a  = w_accept && !w_dst;
    w_acc_b  = w_accept && w_dst;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_a     <= '0;
      r_valid_a <= 1'b0;
    end else if (w_acc_a) begin
      r_q_a     <= din;
      r_valid_a <= 1'b1;
    end else if (ready_a) begin
      r_valid_a <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_b     <= '0;
      r_valid_b <= 1'b0;
    end else if (w_acc_b) begin
      r_q_b     <= din;
      r_valid_b <= 1'b1;
    end else if (ready_b) begin
      r_valid_b <= 1'b0;
    end
  end

  // clr wins over a same-edge increment or toggle; the data path ignores clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_turn  <= 1'b0;
    end else if (clr) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_turn  <= 1'b0;
    end else begin
      if (w_acc_a)          r_cnt_a <= r_cnt_a + 1'b1;
      if (w_acc_b)          r_cnt_b <= r_cnt_b + 1'b1;
      if (w_accept && auto) r_turn  <= ~r_turn;
    end
  end

  assign q_a     = r_q_a;
  assign valid_a = r_valid_a;
  assign q_b     = r_q_b;
  assign valid_b = r_valid_b;
  assign cnt_a   = r_cnt_a;
  assign cnt_b   = r_cnt_b;

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed vector table, corner-case
// sequences and randomized traffic against a slot-level reference model.
module tb_demux_stream;
  localparam int WIDTH = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             in_valid, in_ready, s, auto, clr;
  logic [WIDTH-1:0] q_a, q_b;
  logic             valid_a, valid_b, ready_a, ready_b;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  int unsigned total = 0;
  int unsigned bad   = 0;

  demux_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .auto(auto), .clr(clr),
    .q_a(q_a), .valid_a(valid_a), .ready_a(ready_a),
    .q_b(q_b), .valid_b(valid_b), .ready_b(ready_b),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 clk = ~clk;

  // Reference model: two one-word slots indexed by channel (0 = A, 1 = B)
  logic [WIDTH-1:0] m_q[2];
  bit               m_v[2];
  int unsigned      m_cnt[2];
  bit               m_turn;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_q[c] = '0; m_v[c] = 0; m_cnt[c] = 0;
    end
    m_turn = 0;
  endtask

  function automatic int m_dst();
    return auto ? int'(m_turn) : int'(s);
  endfunction

  function automatic bit m_ready();
    bit rdy[2];
    rdy[0] = ready_a; rdy[1] = ready_b;
    return !m_v[m_dst()] || rdy[m_dst()];
  endfunction

  task automatic model_edge();
    bit rdy[2];
    bit acc;
    int d;
    rdy[0] = ready_a; rdy[1] = ready_b;
    d   = m_dst();
    acc = in_valid && m_ready();
    for (int c = 0; c < 2; c++) begin
      if (acc && d == c) begin
        m_q[c] = din; m_v[c] = 1; m_cnt[c] = (m_cnt[c] + 1) % (1 << CNT_W);
      end else if (rdy[c]) begin
        m_v[c] = 0;
      end
    end
    if (clr) begin
      m_cnt[0] = 0; m_cnt[1] = 0; m_turn = 0;
    end else if (acc && auto) begin
      m_turn = ~m_turn;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit sel, input bit au,
                       input bit ra, input bit rb, input bit cl);
    in_valid = v; din = d; s = sel; auto = au; ready_a = ra; ready_b = rb; clr = cl;
  endtask

  // One clock: check in_ready before the edge, model the edge, check registers after it
  task automatic tick();
    #1;
    chk("in_ready(model)", {31'b0, in_ready}, {31'b0, m_ready()});
    model_edge();
    @(posedge clk); #1;
    chk("q_a(model)",     {30'b0, q_a},     {30'b0, m_q[0]});
    chk("valid_a(model)", {31'b0, valid_a}, {31'b0, m_v[0]});
    chk("q_b(model)",     {30'b0, q_b},     {30'b0, m_q[1]});
    chk("valid_b(model)", {31'b0, valid_b}, {31'b0, m_v[1]});
    chk("cnt_a(model)",   {24'b0, cnt_a},   m_cnt[0]);
    chk("cnt_b(model)",   {24'b0, cnt_b},   m_cnt[1]);
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    model_reset();
    drive(0, '0, 0, 0, 0, 0, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit v; logic [1:0] d; bit sel, au, ra, rb, cl;
    bit e_rdy; logic [1:0] e_qa; bit e_va; logic [1:0] e_qb; bit e_vb;
    int unsigned e_ca, e_cb;
  } vec_t;

  vec_t vt[13];

  initial begin
    // v  d     s  au ra rb cl | rdy qa    va qb    vb ca cb
    vt[0]  = '{1, 2'b01, 0, 0, 1, 1, 0, 1, 2'b01, 1, 2'b00, 0, 1, 0};
    vt[1]  = '{1, 2'b10, 1, 0, 1, 1, 0, 1, 2'b01, 0, 2'b10, 1, 1, 1};
    vt[2]  = '{0, 2'b00, 0, 0, 1, 1, 0, 1, 2'b01, 0, 2'b10, 0, 1, 1};
    vt[3]  = '{1, 2'b11, 0, 0, 0, 1, 0, 1, 2'b11, 1, 2'b10, 0, 2, 1};
    vt[4]  = '{1, 2'b00, 0, 0, 0, 1, 0, 0, 2'b11, 1, 2'b10, 0, 2, 1};
    vt[5]  = '{1, 2'b00, 0, 0, 1, 1, 0, 1, 2'b00, 1, 2'b10, 0, 3, 1};
    vt[6]  = '{0, 2'b00, 0, 0, 1, 1, 0, 1, 2'b00, 0, 2'b10, 0, 3, 1};
    vt[7]  = '{0, 2'b00, 0, 0, 1, 1, 1, 1, 2'b00, 0, 2'b10, 0, 0, 0};
    vt[8]  = '{1, 2'b00, 1, 1, 1, 1, 0, 1, 2'b00, 1, 2'b10, 0, 1, 0};
    vt[9]  = '{1, 2'b01, 0, 1, 1, 1, 0, 1, 2'b00, 0, 2'b01, 1, 1, 1};
    vt[10] = '{1, 2'b10, 1, 1, 1, 1, 0, 1, 2'b10, 1, 2'b01, 0, 2, 1};
    vt[11] = '{1, 2'b11, 0, 1, 1, 1, 0, 1, 2'b10, 0, 2'b11, 1, 2, 2};
    vt[12] = '{0, 2'b00, 0, 1, 1, 1, 0, 1, 2'b10, 0, 2'b11, 0, 2, 2};

    rst_n = 1'b0;
    drive(0, '0, 0, 0, 0, 0, 0);
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("reset valid_a", {31'b0, valid_a}, 32'd0);
    chk("reset valid_b", {31'b0, valid_b}, 32'd0);
    chk("reset cnt_a",   {24'b0, cnt_a},   32'd0);
    chk("reset q_b",     {30'b0, q_b},     32'd0);

    // Directed vectors: routing, backpressure, clr, auto alternation
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].v, vt[i].d, vt[i].sel, vt[i].au, vt[i].ra, vt[i].rb, vt[i].cl);
      #1;
      chk($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, vt[i].e_rdy});
      tick();
      chk($sformatf("vec%0d q_a", i),     {30'b0, q_a},     {30'b0, vt[i].e_qa});
      chk($sformatf("vec%0d valid_a", i), {31'b0, valid_a}, {31'b0, vt[i].e_va});
      chk($sformatf("vec%0d q_b", i),     {30'b0, q_b},     {30'b0, vt[i].e_qb});
      chk($sformatf("vec%0d valid_b", i), {31'b0, valid_b}, {31'b0, vt[i].e_vb});
      chk($sformatf("vec%0d cnt_a", i),   {24'b0, cnt_a},   vt[i].e_ca);
      chk($sformatf("vec%0d cnt_b", i),   {24'b0, cnt_b},   vt[i].e_cb);
    end

    // Asynchronous reset between edges with A holding a word
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'(i + 1), 0, 0, 1, 1, 0);
      tick();
    end
    drive(0, '0, 0, 0, 0, 1, 0);
    tick();
    chk("midrst pre valid_a", {31'b0, valid_a}, 32'd1);
    chk("midrst pre cnt_a",   {24'b0, cnt_a},   32'd5);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst valid_a", {31'b0, valid_a}, 32'd0);
    chk("midrst q_a",     {30'b0, q_a},     32'd0);
    chk("midrst cnt_a",   {24'b0, cnt_a},   32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Counter wrap after 256 accepts, then clr on the same edge as an accept into B
    for (int i = 0; i < 256; i++) begin
      drive(1, 2'($urandom), 0, 0, 1, 1, 0);
      tick();
    end
    chk("wrap cnt_a", {24'b0, cnt_a}, 32'd0);
    drive(1, 2'b01, 0, 1, 1, 0, 0);
    tick();
    drive(1, 2'b10, 0, 1, 1, 0, 1);
    tick();
    chk("clr cnt_b",   {24'b0, cnt_b},   32'd0);
    chk("clr valid_b", {31'b0, valid_b}, 32'd1);
    chk("clr q_b",     {30'b0, q_b},     32'd2);
    drive(1, 2'b11, 0, 1, 1, 0, 0);
    tick();
    chk("clr turn->A q_a", {30'b0, q_a}, 32'd3);
    chk("clr turn->A cnt_a", {24'b0, cnt_a}, 32'd1);

    // Head-of-line block: turn = B, B full and stalled, A empty
    do_reset();
    drive(1, 2'b01, 0, 1, 1, 0, 0); tick();
    drive(1, 2'b10, 0, 1, 1, 0, 0); tick();
    drive(1, 2'b11, 0, 1, 1, 0, 0); tick();
    drive(0, 2'b00, 0, 1, 1, 0, 0); tick();
    drive(1, 2'b00, 0, 1, 1, 0, 0);
    #1;
    chk("hol in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("hol q_b hold", {30'b0, q_b}, 32'd2);
    drive(1, 2'b00, 0, 1, 1, 1, 0);
    #1;
    chk("hol release in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("hol q_b new", {30'b0, q_b}, 32'd0);
    drive(1, 2'b01, 0, 1, 0, 0, 0);
    tick();
    chk("hol turn->A valid_a", {31'b0, valid_a}, 32'd1);
    chk("hol turn->A q_a",     {30'b0, q_a},     32'd1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom),
            (i / 200) % 2 == 1 ? $urandom_range(0, 15) != 0 : $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 40) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
